yutorina_id_stage: RTL

Instruction-decode stage of the Yutorina pipeline, directly downstream of the IF stage. It consumes `if_pc`/`if_insn`/`if_en_`, reads two GPR operands, resolves operand hazards, computes branch outcome and target for the IF stage, and registers a decoded control bundle into the EX stage.

---
 rtl/yutorina_id_stage.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/yutorina_id_stage.sv
// Yutorina ID stage: decodes the IF instruction, resolves operand hazards and branch redirects,
// and registers the EX control bundle. Define ID_FWD_EN to enable EX/MEM operand forwarding.
module yutorina_id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [29:0] if_pc,
   input  logic [31:0] if_insn,
   input  logic        if_en_,
   output logic [4:0]  gpr_rd_addr_0,
   output logic [4:0]  gpr_rd_addr_1,
   input  logic [31:0] gpr_rd_data_0,
   input  logic [31:0] gpr_rd_data_1,
   input  logic        ex_en_,
   input  logic        ex_gpr_we_,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_dst_addr,
   input  logic [31:0] ex_fwd_data,
   input  logic        mem_en_,
   input  logic        mem_gpr_we_,
   input  logic [4:0]  mem_dst_addr,
   input  logic [31:0] mem_fwd_data,
   output logic        hazard,
   output logic        br_taken,
   output logic [29:0] br_addr,
   output logic [29:0] id_pc,
   output logic        id_en_,
   output logic [3:0]  id_alu_op,
   output logic [31:0] id_alu_in_0,
   output logic [31:0] id_alu_in_1,
   output logic [1:0]  id_mem_op,
   output logic [31:0] id_mem_wr_data,
   output logic [4:0]  id_dst_addr,
   output logic        id_gpr_we_,
   output logic [1:0]  id_exp_code
);

   localparam logic [5:0] OpAddu  = 6'h00;
   localparam logic [5:0] OpAddui = 6'h01;
   localparam logic [5:0] OpSubu  = 6'h02;
   localparam logic [5:0] OpAnd   = 6'h03;
   localparam logic [5:0] OpOr    = 6'h04;
   localparam logic [5:0] OpXor   = 6'h05;
   localparam logic [5:0] OpLw    = 6'h06;
   localparam logic [5:0] OpSw    = 6'h07;
   localparam logic [5:0] OpBe    = 6'h08;
   localparam logic [5:0] OpBne   = 6'h09;
   localparam logic [5:0] OpJr    = 6'h0A;
   localparam logic [5:0] OpCall  = 6'h0B;
   localparam logic [5:0] OpTrap  = 6'h0C;

   localparam logic [3:0] AluNop  = 4'd0;
   localparam logic [3:0] AluAdd  = 4'd1;
   localparam logic [3:0] AluSub  = 4'd2;
   localparam logic [3:0] AluAnd  = 4'd3;
   localparam logic [3:0] AluOr   = 4'd4;
   localparam logic [3:0] AluXor  = 4'd5;
   localparam logic [3:0] AluPass = 4'd6;

   localparam logic [1:0] MemNop   = 2'd0;
   localparam logic [1:0] MemLoad  = 2'd1;
   localparam logic [1:0] MemStore = 2'd2;

   localparam logic [1:0] ExpNone  = 2'd0;
   localparam logic [1:0] ExpUndef = 2'd1;
   localparam logic [1:0] ExpTrap  = 2'd2;

   logic [5:0]  op;
   logic [4:0]  raAddr, rbAddr, rcAddr;
   logic [31:0] sext;
   logic        exHitA, exHitB, memHitA, memHitB;
   logic [31:0] raVal, rbVal;
   logic        useRa, useRb, brCond;
   logic [29:0] brTarget;
   logic [3:0]  decAluOp;
   logic [31:0] decIn0, decIn1;
   logic [1:0]  decMemOp, decExp;
   logic [4:0]  decDst;
   logic        decWe_;

   logic [29:0] pc_q, pc_d;
   logic        en_q, en_d;
   logic [3:0]  aluOp_q, aluOp_d;
   logic [31:0] aluIn0_q, aluIn0_d, aluIn1_q, aluIn1_d;
   logic [1:0]  memOp_q, memOp_d;
   logic [31:0] memWrData_q, memWrData_d;
   logic [4:0]  dst_q, dst_d;
   logic        gprWe_q, gprWe_d;
   logic [1:0]  expCode_q, expCode_d;

   assign op     = if_insn[31:26];
   assign raAddr = if_insn[25:21];
   assign rbAddr = if_insn[20:16];
   assign rcAddr = if_insn[15:11];
   assign sext   = {{16{if_insn[15]}}, if_insn[15:0]};

   assign gpr_rd_addr_0 = raAddr;
   assign gpr_rd_addr_1 = rbAddr;

   assign exHitA  = !ex_en_ && !ex_gpr_we_ && (ex_dst_addr == raAddr);
   assign exHitB  = !ex_en_ && !ex_gpr_we_ && (ex_dst_addr == rbAddr);
   assign memHitA = !mem_en_ && !mem_gpr_we_ && (mem_dst_addr == raAddr);
   assign memHitB = !mem_en_ && !mem_gpr_we_ && (mem_dst_addr == rbAddr);

`ifdef ID_FWD_EN
   // With forwarding only a load still in EX cannot supply its value in time.
   assign raVal  = exHitA ? ex_fwd_data : (memHitA ? mem_fwd_data : gpr_rd_data_0);
   assign rbVal  = exHitB ? ex_fwd_data : (memHitB ? mem_fwd_data : gpr_rd_data_1);
   assign hazard = ex_is_load && ((useRa && exHitA) || (useRb && exHitB));
`else
   logic unusedFwd;
   assign unusedFwd = ^{ex_fwd_data, mem_fwd_data, ex_is_load};
   assign raVal  = gpr_rd_data_0;
   assign rbVal  = gpr_rd_data_1;
   assign hazard = (useRa && (exHitA || memHitA)) || (useRb && (exHitB || memHitB));
`endif

   assign br_taken = brCond && !if_en_ && !hazard;
   assign br_addr  = brTarget;

   // Opcode decode: source usage, branch condition/target and the EX bundle fields.
   always_comb begin
      useRa    = 1'b1;
      useRb    = 1'b0;
      brCond   = 1'b0;
      brTarget = if_pc + sext[29:0];
      decAluOp = AluNop;
      decIn0   = raVal;
      decIn1   = rbVal;
      decMemOp = MemNop;
      decDst   = rcAddr;
      decWe_   = 1'b1;
      decExp   = ExpNone;
      case (op)
         OpAddu, OpSubu, OpAnd, OpOr, OpXor: begin
            useRb  = 1'b1;
            decWe_ = 1'b0;
            case (op)
               OpAddu:  decAluOp = AluAdd;
               OpSubu:  decAluOp = AluSub;
               OpAnd:   decAluOp = AluAnd;
               OpOr:    decAluOp = AluOr;
               default: decAluOp = AluXor;
            endcase
         end
         OpAddui, OpLw: begin
            decAluOp = AluAdd;
            decIn1   = sext;
            decDst   = rbAddr;
            decWe_   = 1'b0;
            decMemOp = (op == OpLw) ? MemLoad : MemNop;
         end
         OpSw: begin
            useRb    = 1'b1;
            decAluOp = AluAdd;
            decIn1   = sext;
            decMemOp = MemStore;
         end
         OpBe: begin
            useRb  = 1'b1;
            brCond = (raVal == rbVal);
         end
         OpBne: begin
            useRb  = 1'b1;
            brCond = (raVal != rbVal);
         end
         OpJr: begin
            brCond   = 1'b1;
            brTarget = raVal[31:2];
         end
         OpCall: begin
            brCond   = 1'b1;
            brTarget = raVal[31:2];
            decAluOp = AluPass;
            decIn0   = {if_pc, 2'b00};
            decDst   = 5'd31;
            decWe_   = 1'b0;
         end
         OpTrap: begin
            useRa  = 1'b0;
            decExp = ExpTrap;
         end
         default: begin
            useRa  = 1'b0;
            decExp = ExpUndef;
         end
      endcase
   end

   // Stall holds everything; a bubble still tracks the PC so EX sees a coherent address.
   always_comb begin
      pc_d        = pc_q;
      en_d        = en_q;
      aluOp_d     = aluOp_q;
      aluIn0_d    = aluIn0_q;
      aluIn1_d    = aluIn1_q;
      memOp_d     = memOp_q;
      memWrData_d = memWrData_q;
      dst_d       = dst_q;
      gprWe_d     = gprWe_q;
      expCode_d   = expCode_q;
      if (!stall) begin
         pc_d        = if_pc;
         aluIn0_d    = decIn0;
         aluIn1_d    = decIn1;
         memWrData_d = rbVal;
         dst_d       = decDst;
         if (flush || hazard) begin
            en_d      = 1'b1;
            gprWe_d   = 1'b1;
            memOp_d   = MemNop;
            expCode_d = ExpNone;
            aluOp_d   = AluNop;
         end else begin
            en_d      = if_en_;
            gprWe_d   = decWe_ || if_en_;
            memOp_d   = if_en_ ? MemNop : decMemOp;
            expCode_d = decExp;
            aluOp_d   = decAluOp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= '0;
         en_q        <= 1'b1;
         aluOp_q     <= AluNop;
         aluIn0_q    <= '0;
         aluIn1_q    <= '0;
         memOp_q     <= MemNop;
         memWrData_q <= '0;
         dst_q       <= '0;
         gprWe_q     <= 1'b1;
         expCode_q   <= ExpNone;
      end else begin
         pc_q        <= pc_d;
         en_q        <= en_d;
         aluOp_q     <= aluOp_d;
         aluIn0_q    <= aluIn0_d;
         aluIn1_q    <= aluIn1_d;
         memOp_q     <= memOp_d;
         memWrData_q <= memWrData_d;
         dst_q       <= dst_d;
         gprWe_q     <= gprWe_d;
         expCode_q   <= expCode_d;
      end
   end

   assign id_pc          = pc_q;
   assign id_en_         = en_q;
   assign id_alu_op      = aluOp_q;
   assign id_alu_in_0    = aluIn0_q;
   assign id_alu_in_1    = aluIn1_q;
   assign id_mem_op      = memOp_q;
   assign id_mem_wr_data = memWrData_q;
   assign id_dst_addr    = dst_q;
   assign id_gpr_we_     = gprWe_q;
   assign id_exp_code    = expCode_q;

endmodule
